// File: rtl/div_pkg.sv
// Shared definitions for the memory-mapped divider: register offsets,
// STATUS bit positions and the controller state encoding.
package div_pkg;

  localparam logic [4:0] OFF_A      = 5'h00;
  localparam logic [4:0] OFF_B      = 5'h04;
  localparam logic [4:0] OFF_INIT   = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_QUOT   = 5'h10;
  localparam logic [4:0] OFF_REM    = 5'h14;

  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_BUSY = 1;
  localparam int unsigned ST_DZ   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_core.sv
// Restoring divide datapath: one quotient bit per clock, WIDTH iterations
// after start_i. done_o flags the final iteration; quot_o/rem_o are valid then.
module div_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;

  logic [WIDTH:0]   prem_sh;
  logic [WIDTH:0]   prem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] quot_nx;

  // Shift the next dividend bit into the partial remainder, then subtract if it fits.
  always_comb begin
    prem_sh = (prem_q << 1) | (WIDTH + 1)'(dvd_q[WIDTH-1]);
    q_bit   = (prem_sh >= {1'b0, dvs_q});
    prem_nx = q_bit ? (prem_sh - {1'b0, dvs_q}) : prem_sh;
    quot_nx = {quot_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    count_d = count_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    if (start_i) begin
      count_d = CW'(WIDTH);
      prem_d  = '0;
      dvd_d   = dividend_i;
      dvs_d   = divisor_i;
      quot_d  = '0;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
      prem_d  = prem_nx;
      dvd_d   = dvd_q << 1;
      quot_d  = quot_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
    end else begin
      count_q <= count_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
    end
  end

  assign done_o = (count_q == CW'(1));
  assign quot_o = quot_nx;
  assign rem_o  = prem_nx[WIDTH-1:0];

endmodule

// File: rtl/peripheral_div.sv
// Memory-mapped iterative divider: register decode, control FSM, sign fix-up
// and registered read port. Signed mode is built in with PERIPHERAL_DIV_SIGNED_EN.
//
//   state | meaning
//   IDLE  | no operation since reset
//   RUN   | div_core iterating, busy=1, operand and start writes ignored
//   DONE  | result in QUOT/REM, done (and dz) sticky until next start
module peripheral_div
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [31:0]      d_out_q, d_out_d;

  logic [4:0]       reg_off;
  logic [WIDTH-1:0] wdata;
  logic             wr_en, rd_en, start, core_start, core_done;
  logic [WIDTH-1:0] op_a, op_b, core_quot, core_rem, res_quot, res_rem;
  logic [2:0]       status;
  logic [31:0]      rd_data;

  assign reg_off    = addr & 5'h1C;
  assign wdata      = WIDTH'(d_in);
  assign wr_en      = cs & wr;
  assign rd_en      = cs & rd;
  assign start      = wr_en && (reg_off == OFF_INIT) && d_in[0] && (state_q != RUN);
  assign core_start = start && (b_q != '0);

`ifdef PERIPHERAL_DIV_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic a_neg, b_neg;

  assign a_neg    = d_in[1] & a_q[WIDTH-1];
  assign b_neg    = d_in[1] & b_q[WIDTH-1];
  assign op_a     = a_neg ? -a_q : a_q;
  assign op_b     = b_neg ? -b_q : b_q;
  assign res_quot = neg_q_q ? -core_quot : core_quot;
  assign res_rem  = neg_r_q ? -core_rem : core_rem;

  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (start) begin
      neg_q_d = a_neg ^ b_neg;
      neg_r_d = a_neg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  assign op_a     = a_q;
  assign op_b     = b_q;
  assign res_quot = core_quot;
  assign res_rem  = core_rem;
`endif

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst_n      (resetn),
    .start_i    (core_start),
    .dividend_i (op_a),
    .divisor_i  (op_b),
    .done_o     (core_done),
    .quot_o     (core_quot),
    .rem_o      (core_rem)
  );

  always_comb begin
    status          = '0;
    status[ST_DONE] = done_q;
    status[ST_BUSY] = (state_q == RUN);
    status[ST_DZ]   = dz_q;
    case (reg_off)
      OFF_STATUS: rd_data = 32'(status);
      OFF_QUOT:   rd_data = 32'(quot_q);
      OFF_REM:    rd_data = 32'(rem_q);
      default:    rd_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = done_q;
    dz_d    = dz_q;
    d_out_d = d_out_q;

    if (rd_en) d_out_d = rd_data;

    if (wr_en && (state_q != RUN)) begin
      if (reg_off == OFF_A) a_d = wdata;
      if (reg_off == OFF_B) b_d = wdata;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          done_d = 1'b0;
          dz_d   = 1'b0;
          if (b_q == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = a_q;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (core_done) begin
          state_d = DONE;
          quot_d  = res_quot;
          rem_d   = res_rem;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      d_out_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_div.sv
// Bench for peripheral_div: bus tasks queue the expected read data, a monitor
// compares d_out after every cs&rd edge.
module tb_peripheral_div;
  import div_pkg::*;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] d_in;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [31:0] d_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [15:0] a, b, q, r;
  } vec_t;

  vec_t vecs[5];

  peripheral_div #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .d_in   (d_in),
    .cs     (cs),
    .addr   (addr),
    .rd     (rd),
    .wr     (wr),
    .d_out  (d_out)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // All bus tasks are entered at a negedge and return at the following negedge.
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(logic [4:0] off, logic [31:0] data);
    cs = 1'b1; wr = 1'b1; addr = off; d_in = data;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(logic [4:0] off, string name, logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    cs = 1'b1; rd = 1'b1; addr = off;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic run_div(logic [31:0] a, logic [31:0] b, logic [31:0] init);
    wr_reg(OFF_A, a);
    wr_reg(OFF_B, b);
    wr_reg(OFF_INIT, init);
    idle(W);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (cs && rd) begin
        #1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got d_out=0x%08h, expected no read", d_out);
        end else begin
          e = sb.pop_front();
          check(e.name, d_out, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[1] = '{16'd5,    16'd9,    16'd0,    16'd5};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000};
    vecs[3] = '{16'h8000, 16'h0100, 16'h0080, 16'h0000};
    vecs[4] = '{16'd1000, 16'd3,    16'd333,  16'd1};

    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0; resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
    check("reset_dout", d_out, 32'h0);
    rd_reg(OFF_STATUS, "reset_status", 32'h0);
    rd_reg(OFF_QUOT,   "reset_quot",   32'h0);
    rd_reg(OFF_REM,    "reset_rem",    32'h0);

    // 100/7: busy on exactly W consecutive polls, then done
    wr_reg(OFF_A, 32'd100);
    wr_reg(OFF_B, 32'd7);
    wr_reg(OFF_INIT, 32'h1);
    for (int i = 0; i < W; i++) rd_reg(OFF_STATUS, "busy_poll", 32'h2);
    rd_reg(OFF_STATUS, "basic_status", 32'h1);
    rd_reg(OFF_QUOT,   "basic_quot",   32'd14);
    rd_reg(OFF_REM,    "basic_rem",    32'd2);

    // divide by zero finishes one edge after start
    wr_reg(OFF_A, 32'h1234);
    wr_reg(OFF_B, 32'h0);
    wr_reg(OFF_INIT, 32'h1);
    rd_reg(OFF_STATUS, "dz_status", 32'h5);
    rd_reg(OFF_QUOT,   "dz_quot",   32'hFFFF);
    rd_reg(OFF_REM,    "dz_rem",    32'h1234);

    for (int i = 0; i < 5; i++) begin
      run_div(32'(vecs[i].a), 32'(vecs[i].b), 32'h1);
      rd_reg(OFF_STATUS, "vec_status", 32'h1);
      rd_reg(OFF_QUOT,   "vec_quot",   32'(vecs[i].q));
      rd_reg(OFF_REM,    "vec_rem",    32'(vecs[i].r));
    end

    // restart and A write during RUN are ignored
    wr_reg(OFF_A, 32'hFFFF);
    wr_reg(OFF_B, 32'd3);
    wr_reg(OFF_INIT, 32'h1);
    idle(3);
    wr_reg(OFF_A, 32'd9);
    wr_reg(OFF_INIT, 32'h1);
    idle(11);
    rd_reg(OFF_STATUS, "busy_restart_status", 32'h1);
    rd_reg(OFF_QUOT,   "busy_restart_quot",   32'h5555);
    rd_reg(OFF_REM,    "busy_restart_rem",    32'h0);
    wr_reg(OFF_INIT, 32'h1);
    idle(W);
    rd_reg(OFF_QUOT, "run_write_a_ignored", 32'h5555);

    // reset in the middle of an operation
    wr_reg(OFF_A, 32'd1000);
    wr_reg(OFF_B, 32'd3);
    wr_reg(OFF_INIT, 32'h1);
    idle(7);
    resetn = 1'b0;
    #1;
    check("reset_mid_dout", d_out, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    rd_reg(OFF_STATUS, "reset_mid_status", 32'h0);
    rd_reg(OFF_QUOT,   "reset_mid_quot",   32'h0);
    rd_reg(OFF_REM,    "reset_mid_rem",    32'h0);
    run_div(32'd50, 32'd5, 32'h1);
    rd_reg(OFF_REM,  "post_reset_rem",  32'h0);
    rd_reg(OFF_QUOT, "post_reset_quot", 32'd10);

    // bus behaviour
    rd = 1'b1; addr = OFF_STATUS;
    @(negedge clk);
    rd = 1'b0;
    check("dout_hold_no_cs", d_out, 32'd10);
    rd_reg(5'h18, "unmapped_read", 32'h0);
    wr = 1'b1; addr = OFF_A; d_in = 32'd7;
    @(negedge clk);
    addr = OFF_INIT; d_in = 32'h1;
    @(negedge clk);
    wr = 1'b0;
    rd_reg(OFF_STATUS, "cs0_no_start", 32'h1);
    wr_reg(OFF_INIT, 32'h1);
    idle(W);
    rd_reg(OFF_QUOT, "cs0_no_write_a", 32'd10);

    // INIT bit1 (signed select)
    run_div(32'hFFF9, 32'd2, 32'h3);
`ifdef PERIPHERAL_DIV_SIGNED_EN
    rd_reg(OFF_QUOT, "signed_quot", 32'hFFFD);
    rd_reg(OFF_REM,  "signed_rem",  32'hFFFF);
    run_div(32'h8000, 32'hFFFF, 32'h3);
    rd_reg(OFF_STATUS, "signed_ovf_status", 32'h1);
    rd_reg(OFF_QUOT,   "signed_ovf_quot",   32'h8000);
    rd_reg(OFF_REM,    "signed_ovf_rem",    32'h0);
    run_div(32'hFFF9, 32'h0, 32'h3);
    rd_reg(OFF_STATUS, "signed_dz_status", 32'h5);
    rd_reg(OFF_QUOT,   "signed_dz_quot",   32'hFFFF);
    rd_reg(OFF_REM,    "signed_dz_rem",    32'hFFF9);
`else
    rd_reg(OFF_QUOT, "unsigned_init3_quot", 32'h7FFC);
    rd_reg(OFF_REM,  "unsigned_init3_rem",  32'h1);
`endif

    idle(2);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/peripheral_div.md
# peripheral_div

Memory-mapped iterative integer divider on the FemtoRV32 SoC data bus, the divide counterpart of the multiplier peripheral. It sits behind the top-level address decoder at 0x00440000–0x0044001F, takes operands and a start command from CPU stores, and produces quotient, remainder and status for CPU loads. Division is restoring, one quotient bit per clock, so the CPU polls STATUS instead of stalling the bus.

## Interface
- WIDTH, 16, operand, quotient and remainder width in bits (2..32).
- clk  in  1  system clock (27 MHz).
- resetn  in  1  asynchronous, active-low reset.
- d_in  in  32  CPU write data; bits [WIDTH-1:0] used for operands, [1:0] for INIT.
- cs  in  1  chip select from the top-level decoder.
- addr  in  5  byte offset within the block (mem_address[4:0]).
- rd  in  1  read strobe; acted on only when cs=1.
- wr  in  1  write strobe (any byte-mask bit set); acted on only when cs=1.
- d_out  out  32  registered read data, zero-extended.

## Operation
- Register map (addr, word offsets; addr[1:0] ignored):
  - 0x00 A: dividend, W.
  - 0x04 B: divisor, W.
  - 0x08 INIT: W; bit0=1 starts, bit1=signed select.
  - 0x0C STATUS: R; bit0 done, bit1 busy, bit2 dz.
  - 0x10 QUOT: R.
  - 0x14 REM: R.
  - Other offsets read 0; writes to them are ignored.
- FSM states:
  - IDLE --start--> RUN (or DONE when B=0).
  - RUN --count reaches 0--> DONE.
  - DONE --start--> RUN.
- Start: cs&wr at 0x08 with d_in[0]=1, in IDLE or DONE. A start issued in RUN is ignored.
- Writes to A or B during RUN are ignored. Operands are latched at start, so the operation is unaffected.
- Unsigned algorithm:
  - Partial remainder is WIDTH+1 bits.
  - Each RUN cycle shifts in the next dividend MSB and subtracts B if the result is non-negative.
  - The quotient bit is 1 when the subtraction occurs.
- Divide by zero:
  - Result: QUOT = all ones, REM = A, dz=1.
  - DONE is reached on the edge after the start, with no RUN cycles.
- done and dz are sticky until the next accepted start; both clear on start.
- QUOT and REM hold their last results until the next operation completes.
- Reset values: all registers 0, state IDLE, d_out=0, STATUS=0.
- Reset mid-operation aborts the operation immediately; no partial result is retained.

## Timing
- Start write sampled at edge E0:
  - busy=1 is visible after E0.
  - The division runs WIDTH iterations on edges E1..E_WIDTH.
  - After E_WIDTH: done=1, busy=0, and QUOT/REM are valid.
- Fixed latency of WIDTH cycles, independent of operand values and of signed mode.
- Read latency: cs&rd sampled at edge E loads d_out; the value is valid after E and held until the next cs&rd.
- A STATUS read on the same edge as the final iteration returns the pre-edge value (busy=1).
- Simultaneous rd and wr with cs=1: the write takes effect; d_out loads the pre-write register value.

## Configuration
- PERIPHERAL_DIV_SIGNED_EN defined:
  - INIT bit1=1 selects two's-complement division.
  - Operands are converted to magnitudes at start and result signs are fixed on the DONE transition, with no added latency.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case (-2^(WIDTH-1) / -1): QUOT = -2^(WIDTH-1), REM = 0, dz=0.
  - Signed divide by zero: QUOT = all ones, REM = A.
- PERIPHERAL_DIV_SIGNED_EN undefined: INIT bit1 is ignored and all division is unsigned.

## Structure
- Shared package div_pkg holds:
  - register offset constants (OFF_A, OFF_B, OFF_INIT, OFF_STATUS, OFF_QUOT, OFF_REM);
  - STATUS bit indices;
  - the state enum (IDLE, RUN, DONE).
- One sub-module, div_core:
  - contains the iteration datapath (partial remainder, quotient shift register, count down-counter);
  - has a start/done handshake to the top of the block.
- peripheral_div keeps register decode, the FSM, sign handling and the d_out register.

## Test plan
- Basic unsigned: A=100, B=7, INIT=1; poll STATUS -> busy for exactly 16 cycles, then QUOT=14, REM=2, STATUS=0x1.
- Divide by zero: A=0x1234, B=0, start -> after 1 cycle QUOT=0xFFFF, REM=0x1234, STATUS=0x5.
- Start while busy: start 0xFFFF/3, restart 5 cycles later with A=9 -> second start ignored; QUOT=0x5555, REM=0.
- Reset mid-operation: assert resetn=0 at iteration 8 -> immediately STATUS=0, QUOT=0, REM=0, d_out=0; a new 50/5 run gives QUOT=10, REM=0.
- Signed (macro on): A=0xFFF9 (-7), B=2, INIT=3 -> QUOT=0xFFFD, REM=0xFFFF. With the macro off, the same stimulus gives QUOT=0x7FFC, REM=1.
- Bus behaviour:
  - A read of offset 0x18 returns 0.
  - d_out changes only after a cs&rd edge.
  - Writes with cs=0 change nothing.
